// File: rtl/perf_counter_event_master_if.sv
// Avalon-MM write-only link between the event master and the performance
// counter control slave.
interface perf_counter_event_master_if;
    logic [3:0]  avm_address;
    logic        avm_write;
    logic        avm_begintransfer;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_begintransfer,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_begintransfer,
        input  avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/perf_counter_event_master.sv
// Turns per-section start/stop pulses and a global clear pulse into Avalon-MM
// control writes for the performance counter, coalescing events that arrive while pending.
module perf_counter_event_master #(
    parameter int NUM_SECTIONS = 4,
    parameter int DROP_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] start_i,
    input  logic [NUM_SECTIONS-1:0] stop_i,
    input  logic                    clear_i,
    perf_counter_event_master_if.master avm,
    output logic                    busy_o,
    output logic [DROP_W-1:0]       dropped_o
);

    localparam int SUM_W = DROP_W + 4;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                  r_state;
    logic [NUM_SECTIONS-1:0] r_pend_go;
    logic [NUM_SECTIONS-1:0] r_pend_stop;
    logic                    r_pend_clr;
    logic [3:0]              r_address;
    logic                    r_wdata0;
    logic                    r_write;
    logic                    r_begin;
    logic [DROP_W-1:0]       r_dropped;

    logic                    w_any_pend;
    logic                    w_take_clr;
    logic [NUM_SECTIONS-1:0] w_take_stop;
    logic [NUM_SECTIONS-1:0] w_take_go;
    logic [3:0]              w_win_addr;
    logic [NUM_SECTIONS-1:0] w_drop_go;
    logic [NUM_SECTIONS-1:0] w_drop_stop;
    logic                    w_drop_clr;
    logic [3:0]              w_drop_cnt;
    logic [SUM_W-1:0]        w_drop_sum;
    logic [DROP_W-1:0]       w_dropped_next;

    assign w_any_pend = r_pend_clr | (|r_pend_stop) | (|r_pend_go);

    // Winner selection only happens in IDLE; x & -x isolates the lowest set bit.
    always_comb begin
        w_take_clr  = 1'b0;
        w_take_stop = '0;
        w_take_go   = '0;
        w_win_addr  = 4'd0;
        if (r_state == S_IDLE) begin
            if (r_pend_clr) begin
                w_take_clr = 1'b1;
            end else if (|r_pend_stop) begin
                w_take_stop = r_pend_stop & (~r_pend_stop + 1'b1);
            end else if (|r_pend_go) begin
                w_take_go = r_pend_go & (~r_pend_go + 1'b1);
            end
        end
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            if (w_take_stop[i]) w_win_addr = 4'(4 * i);
            if (w_take_go[i])   w_win_addr = 4'(4 * i + 1);
        end
    end

    // A bit being consumed this cycle absorbs a new event without a drop.
    assign w_drop_go   = start_i & r_pend_go   & ~w_take_go;
    assign w_drop_stop = stop_i  & r_pend_stop & ~w_take_stop;
    assign w_drop_clr  = clear_i & r_pend_clr  & ~w_take_clr;

    always_comb begin
        w_drop_cnt = 4'(w_drop_clr);
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            w_drop_cnt = w_drop_cnt + 4'(w_drop_go[i]) + 4'(w_drop_stop[i]);
        end
    end

    assign w_drop_sum     = SUM_W'(r_dropped) + SUM_W'(w_drop_cnt);
    assign w_dropped_next = (w_drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX
                                                           : w_drop_sum[DROP_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pend_go   <= '0;
            r_pend_stop <= '0;
            r_pend_clr  <= 1'b0;
            r_address   <= 4'd0;
            r_wdata0    <= 1'b0;
            r_write     <= 1'b0;
            r_begin     <= 1'b0;
            r_dropped   <= '0;
        end else begin
            r_pend_go   <= (r_pend_go   & ~w_take_go)   | start_i;
            r_pend_stop <= (r_pend_stop & ~w_take_stop) | stop_i;
            r_pend_clr  <= (r_pend_clr  & ~w_take_clr)  | clear_i;
            r_dropped   <= w_dropped_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_pend) begin
                        r_address <= w_win_addr;
                        r_wdata0  <= w_take_clr;
                        r_write   <= 1'b1;
                        r_begin   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_begin <= 1'b0;
                    if (!avm.avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!avm.avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_begin <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign avm.avm_address       = r_address;
    assign avm.avm_writedata     = {31'd0, r_wdata0};
    assign avm.avm_write         = r_write;
    assign avm.avm_begintransfer = r_begin;
    assign busy_o                = w_any_pend | (r_state != S_IDLE);
    assign dropped_o             = r_dropped;

endmodule
